// File: rtl/loc_datapath_pkg.sv
// Shared constants for the location datapath: coordinate/location widths
// and the 2-bit move-direction encoding.
package loc_datapath_pkg;

  localparam int COORD_W = 4;
  localparam int LOC_W   = 8;

  localparam logic [1:0] DIR_YDEC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YINC = 2'b11;

endpackage

// File: rtl/loc_stack.sv
// LIFO of 8-bit locations with a combinational top-of-stack view.
// Pop has priority over push; pushes into a full stack are dropped.
module loc_stack
  import loc_datapath_pkg::*;
#(
  parameter int STACK_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] locIn,
  output logic [LOC_W-1:0] locOut,
  output logic             empStck
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [LOC_W-1:0] mem [STACK_DEPTH];
  logic [CW-1:0]    count;
  logic             full;
  logic             wr_en;

  assign full    = (count == CW'(STACK_DEPTH));
  assign empStck = (count == '0);
  assign wr_en   = !rst && !pop && push && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (pop) begin
      if (!empStck) count <= count - CW'(1);
    end else if (wr_en) begin
      count <= count + CW'(1);
    end
  end

  // Contents are not reset; only the count defines what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[AW'(count)] <= locIn;
  end

  assign locOut = empStck ? '0 : mem[AW'(count - CW'(1))];

endmodule

// File: rtl/loc_datapath.sv
// Location datapath: x/y registers, a 4-bit +/-1 adder on the selected axis,
// wrap detection, and a stack for backtracking to saved locations.
module loc_datapath
  import loc_datapath_pkg::*;
#(
  parameter int STACK_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rgLd,
  input  logic [1:0]       dir,
  input  logic             push,
  input  logic             pop,
  input  logic             adderEn,
  output logic             cntReach,
  output logic             empStck,
  output logic [LOC_W-1:0] nxtLoc,
  output logic [LOC_W-1:0] curLoc
);

  logic [COORD_W-1:0] x_q, y_q;
  logic               sl;
  logic [COORD_W-1:0] coord;
  logic [COORD_W-1:0] step;
  logic [COORD_W-1:0] sum;
  logic [LOC_W-1:0]   stack_top;

  assign curLoc = {x_q, y_q};

  // Directions 01/10 move along x, 00/11 along y; dir[0] picks the sign.
  assign sl    = dir[1] ^ dir[0];
  assign coord = sl ? x_q : y_q;
  assign step  = dir[0] ? 4'h1 : 4'hF;
  assign sum   = adderEn ? (coord + step) : '0;

  assign cntReach = ((coord + {3'b000, dir[0]}) == 4'h0);

  loc_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .locIn  (curLoc),
    .locOut (stack_top),
    .empStck(empStck)
  );

  always_comb begin
    nxtLoc = curLoc;
    if (rst)                nxtLoc = '0;
    else if (pop)           nxtLoc = stack_top;
    else if (adderEn && sl) nxtLoc = {sum, y_q};
    else if (adderEn)       nxtLoc = {x_q, sum};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (rgLd) begin
      x_q <= nxtLoc[7:4];
      y_q <= nxtLoc[3:0];
    end
  end

endmodule

// File: tb/tb_loc_datapath.sv
// Self-checking bench for loc_datapath: reference model of the location
// registers plus an expected-value stack queue checked on every pop.
module tb_loc_datapath;
  import loc_datapath_pkg::*;

  localparam int DEPTH = 256;

  logic       clk;
  logic       rst;
  logic       rgLd;
  logic [1:0] dir;
  logic       push;
  logic       pop;
  logic       adderEn;
  logic       cntReach;
  logic       empStck;
  logic [7:0] nxtLoc;
  logic [7:0] curLoc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];   // model stack; back is the top
  logic [7:0] m_cur;
  logic [7:0] m_nxt;
  logic [7:0] last_acc;

  loc_datapath #(.STACK_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .rgLd    (rgLd),
    .dir     (dir),
    .push    (push),
    .pop     (pop),
    .adderEn (adderEn),
    .cntReach(cntReach),
    .empStck (empStck),
    .nxtLoc  (nxtLoc),
    .curLoc  (curLoc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_move(input logic [7:0] c, input logic [1:0] d);
    logic [3:0] x, y;
    x = c[7:4];
    y = c[3:0];
    case (d)
      DIR_YDEC: y = y - 4'd1;
      DIR_XINC: x = x + 4'd1;
      DIR_XDEC: x = x - 4'd1;
      default:  y = y + 4'd1;
    endcase
    return {x, y};
  endfunction

  function automatic logic model_wrap(input logic [7:0] c, input logic [1:0] d);
    case (d)
      DIR_YDEC: return c[3:0] == 4'h0;
      DIR_XINC: return c[7:4] == 4'hF;
      DIR_XDEC: return c[7:4] == 4'h0;
      default:  return c[3:0] == 4'hF;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic rg, input logic [1:0] d, input logic pu,
                       input logic po, input logic ae);
    rst = 1'b0; rgLd = rg; dir = d; push = pu; pop = po; adderEn = ae;
    #1;
    if (po)      m_nxt = (exp_q.size() != 0) ? exp_q[$] : 8'h00;
    else if (ae) m_nxt = model_move(m_cur, d);
    else         m_nxt = m_cur;
    check("nxtLoc", nxtLoc, m_nxt);
    check("cntReach", {7'd0, cntReach}, {7'd0, model_wrap(m_cur, d)});
    check("empStck", {7'd0, empStck}, {7'd0, exp_q.size() == 0});
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (pop) begin
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end else if (push && exp_q.size() < DEPTH) begin
      exp_q.push_back(m_cur);
    end
    if (rgLd) m_cur = m_nxt;
    #1;
    check("curLoc", curLoc, m_cur);
  endtask

  task automatic do_cycle(input logic rg, input logic [1:0] d, input logic pu,
                          input logic po, input logic ae);
    apply(rg, d, pu, po, ae);
    clock_edge();
  endtask

  // Reset with conflicting controls asserted to show rst overrides them.
  task automatic do_reset();
    rst = 1'b1; rgLd = 1'b1; push = 1'b1; pop = 1'b1; adderEn = 1'b1;
    dir = 2'($urandom_range(0, 3));
    #1;
    check("rst_nxtLoc", nxtLoc, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0; rgLd = 1'b0; push = 1'b0; pop = 1'b0; adderEn = 1'b0;
    m_cur = 8'h00;
    exp_q.delete();
    #1;
    check("rst_curLoc", curLoc, 8'h00);
    check("rst_empStck", {7'd0, empStck}, 8'h01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rgLd = 1'b0; dir = 2'b00; push = 1'b0; pop = 1'b0; adderEn = 1'b0;
    m_cur = 8'h00;
    m_nxt = 8'h00;
    last_acc = 8'h00;
    @(negedge clk);
    do_reset();

    // three x increments
    for (int i = 0; i < 3; i++) do_cycle(1'b1, DIR_XINC, 1'b0, 1'b0, 1'b1);
    check("xinc3_curLoc", curLoc, 8'h30);

    // y wrap upward from 0F
    do_reset();
    do_cycle(1'b1, DIR_YDEC, 1'b0, 1'b0, 1'b1);
    check("ydec_wrap_curLoc", curLoc, 8'h0F);
    apply(1'b0, DIR_YINC, 1'b0, 1'b0, 1'b1);
    check("yinc_wrap_cnt", {7'd0, cntReach}, 8'h01);
    check("yinc_wrap_nxt", nxtLoc, 8'h00);
    clock_edge();

    // y wrap downward from 30
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b1, DIR_XINC, 1'b0, 1'b0, 1'b1);
    apply(1'b0, DIR_YDEC, 1'b0, 1'b0, 1'b1);
    check("ydec_wrap_cnt", {7'd0, cntReach}, 8'h01);
    check("ydec_wrap_nxt", nxtLoc, 8'h3F);
    clock_edge();

    // push 12, push 34, pop twice with rgLd
    do_reset();
    do_cycle(1'b1, DIR_XINC, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, DIR_YINC, 1'b0, 1'b0, 1'b1);
    do_cycle(1'b1, DIR_YINC, 1'b0, 1'b0, 1'b1);
    check("at12", curLoc, 8'h12);
    do_cycle(1'b0, DIR_XINC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) do_cycle(1'b1, DIR_XINC, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) do_cycle(1'b1, DIR_YINC, 1'b0, 1'b0, 1'b1);
    check("at34", curLoc, 8'h34);
    do_cycle(1'b0, DIR_XINC, 1'b1, 1'b0, 1'b0);
    apply(1'b1, DIR_XINC, 1'b0, 1'b1, 1'b1);
    check("pop1_nxt", nxtLoc, 8'h34);
    clock_edge();
    apply(1'b1, DIR_XINC, 1'b0, 1'b1, 1'b1);
    check("pop2_nxt", nxtLoc, 8'h12);
    clock_edge();
    check("pop2_cur", curLoc, 8'h12);
    check("pop2_emp", {7'd0, empStck}, 8'h01);

    // pop on empty, then push+pop with one entry
    apply(1'b0, DIR_XINC, 1'b0, 1'b1, 1'b0);
    check("pop_empty_nxt", nxtLoc, 8'h00);
    clock_edge();
    check("pop_empty_emp", {7'd0, empStck}, 8'h01);
    do_cycle(1'b0, DIR_XINC, 1'b1, 1'b0, 1'b0);
    apply(1'b0, DIR_XINC, 1'b1, 1'b1, 1'b0);
    check("pushpop_nxt", nxtLoc, 8'h12);
    clock_edge();
    check("pushpop_emp", {7'd0, empStck}, 8'h01);

    // fill to depth with random moves, then push AA into the full stack
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      last_acc = m_cur;
      do_cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 16 && m_cur[7:4] != 4'hA; i++)
      do_cycle(1'b1, DIR_XINC, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16 && m_cur[3:0] != 4'hA; i++)
      do_cycle(1'b1, DIR_YINC, 1'b0, 1'b0, 1'b1);
    check("at_AA", curLoc, 8'hAA);
    do_cycle(1'b0, DIR_XINC, 1'b1, 1'b0, 1'b0);
    apply(1'b0, DIR_XINC, 1'b0, 1'b1, 1'b0);
    check("full_pop_nxt", nxtLoc, last_acc);
    clock_edge();

    // random traffic
    do_reset();
    for (int i = 0; i < 300; i++)
      do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) != 0));

    // reset mid-traversal with three entries stacked
    do_reset();
    do_cycle(1'b1, DIR_XINC, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b1, DIR_YINC, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b1, DIR_XINC, 1'b1, 1'b0, 1'b1);
    check("mid_emp_before", {7'd0, empStck}, 8'h00);
    do_reset();
    do_cycle(1'b0, DIR_XINC, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loc_datapath.md
LOC_DATAPATH -- requirements
Module: loc_datapath

Interface
REQ-001 Parameter STACK_DEPTH, default 256, number of 8-bit location entries the stack holds.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rgLd  input  1  loads nxtLoc into the location registers at the clock edge.
REQ-005 dir  input  2  move direction: 00 = y-1, 01 = x+1, 10 = x-1, 11 = y+1.
REQ-006 push  input  1  pushes curLoc onto the stack at the clock edge.
REQ-007 pop  input  1  selects the stack top onto nxtLoc and removes it at the clock edge.
REQ-008 adderEn  input  1  enables the 4-bit adder; selects the adder result onto nxtLoc.
REQ-009 cntReach  output  1  high when the requested move would wrap the selected coordinate.
REQ-010 empStck  output  1  high when the stack holds no entries.
REQ-011 nxtLoc  output  8  combinational next location {x[3:0], y[3:0]}.
REQ-012 curLoc  output  8  registered current location {x[3:0] = bits 7:4, y[3:0] = bits 3:0}.

Function
REQ-013 Axis select sl = dir[1] XOR dir[0]; sl=1 selects x (curLoc[7:4]), sl=0 selects y (curLoc[3:0]).
REQ-014 Step = +1 when dir[0]=1, else -1 (4'hF); adder sum = selected coordinate + step, modulo 16.
REQ-015 Adder with adderEn=0 drives sum 4'h0 and carry 0; carry-out is internal and unused at the ports.
REQ-016 cntReach = ((selected coordinate + dir[0]) mod 16 == 0): high for coordinate 15 with dir[0]=1, or coordinate 0 with dir[0]=0; purely combinational, independent of adderEn.
REQ-017 nxtLoc priority: rst -> 8'h00; else pop -> stack top; else adderEn and sl -> {sum, curLoc[3:0]}; else adderEn and not sl -> {curLoc[7:4], sum}; else curLoc (no latch).
REQ-018 Location registers are two 4-bit registers; on a clock edge with rgLd=1 they capture nxtLoc, otherwise hold.
REQ-019 Stack is LIFO of 8-bit entries; push writes curLoc (pre-edge value) at the top and increments the count at the clock edge.
REQ-020 Stack top (most recent entry) is visible combinationally; pop decrements the count at the clock edge.
REQ-021 Pop on empty stack: no change, stack top reads 8'h00.
REQ-022 Push on full stack (count = STACK_DEPTH): push ignored, contents unchanged.
REQ-023 push and pop in the same cycle: pop wins, push ignored.
REQ-024 pop with rgLd=1 in the same cycle restores the popped location into curLoc at that edge.
REQ-025 empStck = (count == 0), combinational from the registered count.

Reset
REQ-026 On a clock edge with rst=1: curLoc = 8'h00, stack count = 0 (empStck = 1); stack contents need not be cleared.
REQ-027 While rst=1, nxtLoc = 8'h00 regardless of other inputs; rst overrides push, pop and rgLd.
REQ-028 Reset asserted mid-traversal discards all pushed locations at that edge.

Structure
REQ-029 Shared package holds the dir encoding constants (DIR_YDEC=00, DIR_XINC=01, DIR_XDEC=10, DIR_YINC=11), the 4-bit coordinate width and the 8-bit location width.
REQ-030 One sub-module, loc_stack (clk, rst, push, pop, locIn[7:0], locOut[7:0], empStck); adder and registers are inlined.

Verification
REQ-031 Reset, then rgLd=1, adderEn=1, dir=01 for three cycles -> curLoc = 8'h30, cntReach = 0 throughout.
REQ-032 curLoc = 8'h0F, dir=11, adderEn=1 -> cntReach = 1, nxtLoc = 8'h00 (y wraps); dir=00 from curLoc = 8'h30 -> cntReach = 1, nxtLoc = 8'h3F.
REQ-033 Push at curLoc = 8'h12, then at 8'h34, then pop with rgLd=1 -> nxtLoc = 8'h34 during the first pop; second pop -> 8'h12; empStck = 1 after the second pop edge.
REQ-034 Pop on empty stack -> nxtLoc = 8'h00, empStck stays 1; push and pop together with one entry -> entry popped, count 0.
REQ-035 Fill STACK_DEPTH entries, then push 8'hAA -> push ignored, the first pop returns the last accepted entry.
REQ-036 With 3 entries pushed, assert rst for one edge -> curLoc = 8'h00, empStck = 1, nxtLoc = 8'h00 while rst is high.
